// File: rtl/alu_seq.sv
// Execute-stage ALU: single-cycle add/compare/logic ops plus a radix-2 iterative
// RV32M-style multiply/divide unit, with valid/ready issue and registered results.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Select,
    output logic             out_valid,
    output logic [WIDTH-1:0] Result,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic             LT,
    output logic             ULT
);
    localparam int unsigned W  = WIDTH;
    localparam int unsigned W1 = WIDTH + 1;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [2:0] GRP_ADD  = 3'b000;
    localparam logic [2:0] GRP_MUL  = 3'b001;
    localparam logic [2:0] GRP_SLT  = 3'b010;
    localparam logic [2:0] GRP_SLTU = 3'b011;
    localparam logic [2:0] GRP_XOR  = 3'b100;
    localparam logic [2:0] GRP_DIV  = 3'b101;
    localparam logic [2:0] GRP_OR   = 3'b110;
    localparam logic [2:0] GRP_AND  = 3'b111;

    typedef enum logic [1:0] {IDLE, RUN_MUL, RUN_DIV} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          accept, last, is_mul, is_div, is_seq;

    // Iterative unit state
    logic [PW-1:0] prod_q;
    logic [W-1:0]  mcand_q, rem_q, quo_q, a_q;
    logic [1:0]    op_q;
    logic          neg_q, rneg_q, dz_q, ovf_q, lt_q, ult_q;

    // Next-state and issue control
    always_comb begin
        state_d  = state_q;
        in_ready = (state_q == IDLE) & ~rst;
        is_mul   = (Select[4:2] == GRP_MUL);
        is_div   = (Select[4:2] == GRP_DIV);
        is_seq   = is_mul | is_div;
        accept   = in_valid & in_ready;
        last     = (state_q != IDLE) && (cnt_q == CW'(W - 1));
        case (state_q)
            IDLE: begin
                if (accept && is_mul)      state_d = RUN_MUL;
                else if (accept && is_div) state_d = RUN_DIV;
            end
            RUN_MUL, RUN_DIV: begin
                if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == IDLE || last) ? '0 : cnt_q + CW'(1);
        end
    end

    // Single-cycle datapath
    logic [W-1:0] b_op, alu_res;
    logic [W:0]   sum;
    logic         add_c, add_v, lt_c, ult_c;

    always_comb begin
        b_op  = Select[1] ? ~B : B;
        sum   = {1'b0, A} + {1'b0, b_op} + W1'(Select[0]);
        lt_c  = $signed(A) < $signed(B);
        ult_c = A < B;
        add_c = (Select[4:2] == GRP_ADD) & sum[W];
        add_v = (Select[4:2] == GRP_ADD) & (A[W-1] == b_op[W-1]) & (sum[W-1] != A[W-1]);
        case (Select[4:2])
            GRP_ADD:  alu_res = sum[W-1:0];
            GRP_SLT:  alu_res = W'(lt_c);
            GRP_SLTU: alu_res = W'(ult_c);
            GRP_XOR:  alu_res = A ^ B;
            GRP_OR:   alu_res = A | B;
            GRP_AND:  alu_res = A & B;
            default:  alu_res = '0;
        endcase
    end

    // Operand magnitudes for the iterative unit
    logic         a_sgn, b_sgn, a_neg, b_neg;
    logic [W-1:0] a_mag, b_mag;

    always_comb begin
        a_sgn = is_mul ? (Select[1] ^ Select[0]) : ~Select[0];
        b_sgn = is_mul ? (Select[1:0] == 2'b01) : ~Select[0];
        a_neg = a_sgn & A[W-1];
        b_neg = b_sgn & B[W-1];
        a_mag = a_neg ? -A : A;
        b_mag = b_neg ? -B : B;
    end

    // One shift-add / restoring-subtract step, plus final sign fix-up
    logic [W:0]    msum, rshift, diff;
    logic [PW-1:0] prod_nxt, prod_fix;
    logic [W-1:0]  rem_nxt, quo_nxt, rem_fix, quo_fix, seq_res;

    always_comb begin
        msum     = {1'b0, prod_q[PW-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : W1'(0));
        prod_nxt = {msum, prod_q[W-1:1]};
        prod_fix = neg_q ? -prod_nxt : prod_nxt;
        rshift   = {rem_q, quo_q[W-1]};
        diff     = rshift - {1'b0, mcand_q};
        rem_nxt  = diff[W] ? rshift[W-1:0] : diff[W-1:0];
        quo_nxt  = {quo_q[W-2:0], ~diff[W]};
        quo_fix  = neg_q ? -quo_nxt : quo_nxt;
        rem_fix  = rneg_q ? -rem_nxt : rem_nxt;
        if (dz_q) begin
            quo_fix = '1;
            rem_fix = a_q;
        end else if (ovf_q) begin
            quo_fix = {1'b1, {(W - 1){1'b0}}};
            rem_fix = '0;
        end
        if (state_q == RUN_MUL) seq_res = (op_q == 2'b00) ? prod_fix[W-1:0] : prod_fix[PW-1:W];
        else                    seq_res = op_q[1] ? rem_fix : quo_fix;
    end

    logic         wr_single, wr;
    logic [W-1:0] res_d;

    always_comb begin
        wr_single = accept & ~is_seq;
        wr        = wr_single | last;
        res_d     = last ? seq_res : alu_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            Result    <= '0;
            N         <= 1'b0;
            Z         <= 1'b0;
            C         <= 1'b0;
            V         <= 1'b0;
            LT        <= 1'b0;
            ULT       <= 1'b0;
            prod_q    <= '0;
            mcand_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            a_q       <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            lt_q      <= 1'b0;
            ult_q     <= 1'b0;
        end else begin
            out_valid <= wr;
            if (wr) begin
                Result <= res_d;
                N      <= res_d[W-1];
                Z      <= ~|res_d;
                C      <= wr_single & add_c;
                V      <= wr_single & add_v;
                LT     <= last ? lt_q : lt_c;
                ULT    <= last ? ult_q : ult_c;
            end
            if (accept && is_seq) begin
                prod_q  <= PW'(a_mag);
                mcand_q <= b_mag;
                rem_q   <= '0;
                quo_q   <= a_mag;
                a_q     <= A;
                op_q    <= Select[1:0];
                neg_q   <= a_neg ^ b_neg;
                rneg_q  <= a_neg;
                dz_q    <= (B == '0);
                ovf_q   <= ~Select[0] & (A == {1'b1, {(W - 1){1'b0}}}) & (B == '1);
                lt_q    <= lt_c;
                ult_q   <= ult_c;
            end else if (state_q == RUN_MUL) begin
                prod_q <= prod_nxt;
            end else if (state_q == RUN_DIV) begin
                rem_q <= rem_nxt;
                quo_q <= quo_nxt;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors push expectations, a monitor
// pops and compares on every out_valid; a WIDTH=8 instance covers busy-drop.
module tb_alu_seq;
    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid;
    logic [W-1:0]  A, B, Result;
    logic [4:0]    Select;
    logic          N, Z, C, V, LT, ULT;

    logic          in_valid8, in_ready8, out_valid8;
    logic [7:0]    A8, B8, Result8;
    logic [4:0]    Select8;
    logic          N8, Z8, C8, V8, LT8, ULT8;

    int checks = 0;
    int errors = 0;
    int cnt8   = 0;

    typedef struct {
        logic [31:0] r;
        logic [5:0]  f;
        string       name;
    } exp_t;

    exp_t q[$];

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Select(Select), .out_valid(out_valid), .Result(Result),
        .N(N), .Z(Z), .C(C), .V(V), .LT(LT), .ULT(ULT)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .A(A8), .B(B8), .Select(Select8), .out_valid(out_valid8), .Result(Result8),
        .N(N8), .Z(Z8), .C(C8), .V(V8), .LT(LT8), .ULT(ULT8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // {N,Z,C,V,LT,ULT}; C/V supplied by hand, the rest follow from result and operands
    function automatic logic [5:0] flags(input logic [31:0] r, input logic [31:0] a,
                                         input logic [31:0] b, input logic c, input logic v);
        return {r[31], r == 32'd0, c, v, $signed(a) < $signed(b), a < b};
    endfunction

    task automatic present(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                           input string name, output logic ok);
        int waited;
        A = a; B = b; Select = sel; in_valid = 1'b1;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        ok = (in_ready === 1'b1);
        if (!ok) begin
            chk({name, " accept timeout"}, 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end
    endtask

    task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic c, input logic v, input string name);
        logic ok;
        exp_t e;
        present(sel, a, b, name, ok);
        if (ok) begin
            e.r = r; e.f = flags(r, a, b, c, v); e.name = name;
            q.push_back(e);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic start_raw(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                             input string name);
        logic ok;
        present(sel, a, b, name, ok);
        if (ok) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Monitor: compare every presented result against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("spurious out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk({e.name, " result"}, Result, e.r);
                    chk({e.name, " flags NZCV/LT/ULT"}, 32'({N, Z, C, V, LT, ULT}), 32'(e.f));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (out_valid8 === 1'b1) cnt8++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int busy;
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Select = '0;
        in_valid8 = 1'b0; A8 = '0; B8 = '0; Select8 = '0;
        repeat (3) @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset Result", Result, 32'd0);
        chk("reset flags", 32'({N, Z, C, V, LT, ULT}), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready after reset", 32'(in_ready), 32'd1);

        // Single-cycle ops
        issue(5'b00000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, "ADD overflow");
        chk("ADD latency out_valid", 32'(out_valid), 32'd1);
        issue(5'b00011, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, "SUB equal");
        chk("b2b ready 1", 32'(in_ready), 32'd1);
        issue(5'b01000, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, "SLT");
        chk("b2b ready 2", 32'(in_ready), 32'd1);
        issue(5'b01100, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, "SLTU");
        chk("b2b ready 3", 32'(in_ready), 32'd1);
        issue(5'b10000, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFF00_12CB, 1'b0, 1'b0, "XOR");
        issue(5'b11000, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFFF0_12FF, 1'b0, 1'b0, "OR");
        issue(5'b11100, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h00F0_0034, 1'b0, 1'b0, "AND");
        @(negedge clk);
        chk("hold out_valid low", 32'(out_valid), 32'd0);
        chk("hold Result", Result, 32'h00F0_0034);

        // Multiply: busy window then result
        issue(5'b00111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, "MULHU max");
        busy = 0;
        for (int i = 0; i < 32; i++) begin
            if (in_ready === 1'b0) busy++;
            chk("MULHU no early out_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        chk("MULHU busy cycles", 32'(busy), 32'd32);
        chk("MULHU out_valid at t+33", 32'(out_valid), 32'd1);
        chk("MULHU ready at t+33", 32'(in_ready), 32'd1);
        issue(5'b00100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "MUL max");
        issue(5'b00101, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 1'b0, 1'b0, "MULH -3*7");
        issue(5'b00100, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0, 1'b0, "MUL -3*7");

        // Divide corner cases
        issue(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, "DIV overflow");
        issue(5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, "REM overflow");
        issue(5'b10101, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, "DIVU by zero");
        issue(5'b10111, 32'd7, 32'd0, 32'd7, 1'b0, 1'b0, "REMU by zero");
        issue(5'b10100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0, "DIV -7/2");
        issue(5'b10110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, "REM -7/2");

        // Reset mid-divide: aborted op must produce nothing
        start_raw(5'b10100, 32'd100, 32'd3, "DIV aborted");
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort Result", Result, 32'd0);
        chk("abort flags", 32'({N, Z, C, V, LT, ULT}), 32'd0);
        chk("abort in_ready in reset", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort in_ready after reset", 32'(in_ready), 32'd1);
        repeat (25) @(negedge clk);
        chk("abort Result stays 0", Result, 32'd0);
        issue(5'b00000, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, "ADD after abort");
        chk("ADD after abort latency", 32'(out_valid), 32'd1);

        // WIDTH=8: multiply with a dropped op presented while busy
        @(negedge clk);
        A8 = 8'h0F; B8 = 8'h11; Select8 = 5'b00100; in_valid8 = 1'b1;
        chk("w8 ready before", 32'(in_ready8), 32'd1);
        @(negedge clk);
        A8 = 8'h01; B8 = 8'h01; Select8 = 5'b00000;
        busy = 0;
        for (int i = 0; i < 8; i++) begin
            if (in_ready8 === 1'b0) busy++;
            @(negedge clk);
        end
        in_valid8 = 1'b0;
        chk("w8 busy cycles", 32'(busy), 32'd8);
        chk("w8 out_valid at t+9", 32'(out_valid8), 32'd1);
        chk("w8 MUL result", 32'(Result8), 32'h0000_00FF);
        chk("w8 flags", 32'({N8, Z8, C8, V8, LT8, ULT8}), 32'(6'b100011));

        repeat (40) @(negedge clk);
        chk("scoreboard drained", 32'(q.size()), 32'd0);
        chk("w8 out_valid count", 32'(cnt8), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
